// File: rtl/montgomery_ladder_ctrl.sv
// X448 Montgomery ladder sequencer: walks the scalar MSB->LSB around one
// montgomery_step instance and presents the projective R0 (x:z) at the end.
module montgomery_ladder_ctrl #(
    parameter int WIDTH = 448,
    parameter int BITS  = 448,
    parameter int CLAMP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] scalar,
    input  logic [WIDTH-1:0] u_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] z_out,
    output logic             step_reset,
    output logic             step_enable,
    output logic [WIDTH-1:0] step_x1,
    output logic [WIDTH-1:0] step_z1,
    output logic [WIDTH-1:0] step_x2,
    output logic [WIDTH-1:0] step_z2,
    output logic [WIDTH-1:0] step_px,
    input  logic [WIDTH-1:0] step_x_pd,
    input  logic [WIDTH-1:0] step_z_pd,
    input  logic [WIDTH-1:0] step_x_pa,
    input  logic [WIDTH-1:0] step_z_pa,
    input  logic             step_done
);

    localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SWAP    = 3'd2;
    localparam logic [2:0] S_KICK    = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;
    localparam logic [2:0] S_FINAL   = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_k, r_u;
    logic [WIDTH-1:0] r_x0, r_z0, r_x1, r_z1;
    logic [WIDTH-1:0] r_xout, r_zout;
    logic             r_swap;
    logic [IW-1:0]    r_idx;

    logic [WIDTH-1:0] w_kc;
    logic             w_bit;

    always_comb begin
        w_kc = r_k;
        if (CLAMP != 0) begin
            w_kc[1:0]    = 2'b00;
            w_kc[BITS-1] = 1'b1;
        end
    end

    assign w_bit = r_k[r_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_u     <= '0;
            r_x0    <= '0;
            r_z0    <= '0;
            r_x1    <= '0;
            r_z1    <= '0;
            r_xout  <= '0;
            r_zout  <= '0;
            r_swap  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_k     <= scalar;
                    r_u     <= u_in;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_k     <= w_kc;
                    r_x0    <= WIDTH'(1);
                    r_z0    <= '0;
                    r_x1    <= r_u;
                    r_z1    <= WIDTH'(1);
                    r_swap  <= 1'b0;
                    r_idx   <= IW'(BITS - 1);
                    r_state <= S_SWAP;
                end
                S_SWAP: begin
                    if (r_swap ^ w_bit) begin
                        r_x0 <= r_x1;
                        r_z0 <= r_z1;
                        r_x1 <= r_x0;
                        r_z1 <= r_z0;
                    end
                    r_swap  <= w_bit;
                    r_state <= S_KICK;
                end
                S_KICK: r_state <= S_RUN;
                S_RUN:  if (step_done) r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    r_x0 <= step_x_pd;
                    r_z0 <= step_z_pd;
                    r_x1 <= step_x_pa;
                    r_z1 <= step_z_pa;
                    if (r_idx == '0) begin
                        r_state <= S_FINAL;
                    end else begin
                        r_idx   <= r_idx - IW'(1);
                        r_state <= S_SWAP;
                    end
                end
                S_FINAL: begin
                    // Undo the last pending swap so R0 is the true result.
                    if (r_swap) begin
                        r_x0   <= r_x1;
                        r_z0   <= r_z1;
                        r_x1   <= r_x0;
                        r_z1   <= r_z0;
                        r_xout <= r_x1;
                        r_zout <= r_z1;
                    end else begin
                        r_xout <= r_x0;
                        r_zout <= r_z0;
                    end
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign step_reset  = (r_state == S_IDLE) || (r_state == S_KICK);
    assign step_enable = (r_state == S_RUN);
    assign step_x1     = r_x0;
    assign step_z1     = r_z0;
    assign step_x2     = r_x1;
    assign step_z2     = r_z1;
    assign step_px     = r_u;
    assign x_out       = r_xout;
    assign z_out       = r_zout;

endmodule

// File: tb/tb_montgomery_ladder_ctrl.sv
// Bench for montgomery_ladder_ctrl with a toy step stub (x_pd=x1+1, z_pa=z2+1)
// and a schedule/ladder model derived from the ladder rules.
module tb_montgomery_ladder_ctrl;
    localparam int W = 16;
    localparam int B = 4;

    logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [W-1:0] scalar = '0, u_in = '0;
    logic         busy, done, step_reset, step_enable, step_done;
    logic [W-1:0] x_out, z_out, step_x1, step_z1, step_x2, step_z2, step_px;
    logic [W-1:0] step_x_pd, step_z_pd, step_x_pa, step_z_pa;

    montgomery_ladder_ctrl #(.WIDTH(W), .BITS(B), .CLAMP(0)) dut (
        .clk(clk), .reset(reset), .start(start), .scalar(scalar), .u_in(u_in),
        .busy(busy), .done(done), .x_out(x_out), .z_out(z_out),
        .step_reset(step_reset), .step_enable(step_enable),
        .step_x1(step_x1), .step_z1(step_z1), .step_x2(step_x2), .step_z2(step_z2),
        .step_px(step_px), .step_x_pd(step_x_pd), .step_z_pd(step_z_pd),
        .step_x_pa(step_x_pa), .step_z_pa(step_z_pa), .step_done(step_done)
    );

    always #5 clk = ~clk;

    // Step stub: mode 0 -> done seen on 3rd enabled cycle; mode 1 -> done tied high.
    logic stub_mode = 1'b0;
    logic sdone_r = 1'b0;
    int   scnt = 0;
    always @(posedge clk) begin
        if (step_reset) begin
            scnt    <= 0;
            sdone_r <= 1'b0;
        end else if (step_enable) begin
            scnt <= scnt + 1;
            if (scnt == 1) sdone_r <= 1'b1;
        end
    end
    assign step_done = stub_mode ? 1'b1 : sdone_r;
    assign step_x_pd = step_x1 + W'(1);
    assign step_z_pd = step_z1;
    assign step_x_pa = step_x2;
    assign step_z_pa = step_z2 + W'(1);

    // Ladder model: expected operands per iteration, swap decisions, result.
    logic [W-1:0] m_x1[B], m_z1[B], m_x2[B], m_z2[B];
    logic [B-1:0] m_e;
    logic [W-1:0] m_u, m_xo, m_zo;

    task automatic model(input logic [W-1:0] k, input logic [W-1:0] u);
        logic [W-1:0] ax, az, bx, bz, t;
        logic sw, e;
        ax = 1; az = 0; bx = u; bz = 1; sw = 0; m_u = u;
        for (int i = B - 1; i >= 0; i--) begin
            e = sw ^ k[i];
            if (e) begin
                t = ax; ax = bx; bx = t;
                t = az; az = bz; bz = t;
            end
            sw = k[i];
            m_e[i] = e;
            m_x1[B-1-i] = ax; m_z1[B-1-i] = az;
            m_x2[B-1-i] = bx; m_z2[B-1-i] = bz;
            ax = ax + 1;
            bz = bz + 1;
        end
        if (sw) begin
            m_xo = bx; m_zo = bz;
        end else begin
            m_xo = ax; m_zo = az;
        end
    endtask

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    logic         trk = 1'b0, rst_chk = 1'b0, lit_en = 1'b0;
    logic [W-1:0] lit_x = '0, lit_z = '0;
    logic [B-1:0] lit_e = '0;
    int           ts = 3, lat = 27;

    int   cyc = 0, kicks = 0, dones = 0;
    int   p, j, off;
    logic eb, ed, er, ee;

    // Cycle-accurate schedule check, counted from the cycle after the start-sampling edge.
    always @(negedge clk) begin
        if (!trk) begin
            cyc = 0; kicks = 0; dones = 0;
        end else begin
            cyc++;
            p = 3 + ts;
            eb = (cyc <= lat); ed = (cyc == lat);
            er = (cyc > lat); ee = 1'b0;
            if (cyc >= 2 && cyc <= 1 + B * p) begin
                off = (cyc - 2) % p;
                j   = (cyc - 2) / p;
                er  = (off == 1);
                ee  = (off >= 2 && off < 2 + ts);
                if (off >= 1 && off <= 1 + ts)
                    chk($sformatf("operands it%0d", j), {step_x1, step_z1, step_x2, step_z2, step_px},
                        {m_x1[j], m_z1[j], m_x2[j], m_z2[j], m_u});
            end
            chk($sformatf("busy c%0d", cyc), busy, eb);
            chk($sformatf("done c%0d", cyc), done, ed);
            chk($sformatf("step_reset c%0d", cyc), step_reset, er);
            chk($sformatf("step_enable c%0d", cyc), step_enable, ee);
            if (step_reset && busy) kicks++;
            if (done) dones++;
            if (cyc == lat) begin
                chk("x_out", x_out, m_xo);
                chk("z_out", z_out, m_zo);
                chk("kick count", kicks, B);
                if (lit_en) begin
                    chk("x_out literal", x_out, lit_x);
                    chk("z_out literal", z_out, lit_z);
                    chk("model x literal", m_xo, lit_x);
                    chk("model e trace", m_e, lit_e);
                end
            end
            if (cyc == lat + 6) chk("done count", dones, 1);
        end
        if (rst_chk) begin
            chk("rst busy/done/en", {busy, done, step_enable}, 3'b000);
            chk("rst step_reset", step_reset, 1'b1);
            chk("rst outputs", {x_out, z_out}, '0);
            chk("rst operands", {step_x1, step_z1, step_x2, step_z2, step_px}, '0);
        end
    end

    task automatic run(input logic [W-1:0] k, input logic [W-1:0] u, input logic mode,
                       input logic pulse, input int abort_at, input logic le,
                       input logic [W-1:0] lx, input logic [W-1:0] lz, input logic [B-1:0] lE);
        @(posedge clk); #2;
        scalar = k; u_in = u; stub_mode = mode;
        ts = mode ? 1 : 3;
        lat = 2 + B * (3 + ts) + 1;
        lit_en = le; lit_x = lx; lit_z = lz; lit_e = lE;
        model(k, u);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        trk = 1'b1;
        for (int i = 0; i < lat + 8; i++) begin
            @(posedge clk); #2;
            start = pulse && (i < lat - 4);
            if (abort_at > 0 && i == abort_at) begin
                trk = 1'b0;
                reset = 1'b0;
                rst_chk = 1'b1;
                repeat (3) begin @(posedge clk); #2; end
                reset = 1'b1;
                repeat (2) begin @(posedge clk); #2; end
                rst_chk = 1'b0;
                break;
            end
        end
        trk = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst_chk = 1'b1;
        repeat (2) begin @(posedge clk); #2; end
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #2; end
        rst_chk = 1'b0;

        run(16'hA, 16'd7, 1'b0, 1'b0, 0, 1'b1, 16'd3, 16'd2, 4'b1111);
        run(16'h0, 16'd7, 1'b0, 1'b0, 0, 1'b1, 16'd5, 16'd0, 4'b0000);
        run(16'h6, 16'd5, 1'b0, 1'b0, 0, 1'b1, 16'd3, 16'd2, 4'b0101);
        run(16'hA, 16'd7, 1'b1, 1'b0, 0, 1'b1, 16'd3, 16'd2, 4'b1111);
        run(16'h6, 16'd9, 1'b0, 1'b0, 10, 1'b0, 16'd0, 16'd0, 4'b0000);
        run(16'hA, 16'd7, 1'b0, 1'b0, 0, 1'b1, 16'd3, 16'd2, 4'b1111);
        run(16'hA, 16'd7, 1'b0, 1'b1, 0, 1'b1, 16'd3, 16'd2, 4'b1111);
        run(16'hD, 16'd11, 1'b1, 1'b1, 0, 1'b0, 16'd0, 16'd0, 4'b0000);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/montgomery_ladder_ctrl.md
# montgomery_ladder_ctrl

Sequencer that runs the full X448 Montgomery ladder around one `montgomery_step` instance. It clamps the scalar and initialises R0=(1:0), R1=(u:1). For each scalar bit from MSB to LSB it conditionally swaps R0/R1, launches one combined double-and-add step, and captures the results. It applies the final swap and presents the projective result (x:z) of R0 to the downstream field-inversion stage.

## Interface
Parameters:
- `WIDTH`, 448: field-element width.
- `BITS`, 448: ladder iterations, scalar bits `BITS-1` down to 0.
- `CLAMP`, 1: 1 applies the X448 clamp (bits 1:0 cleared, bit `BITS-1` set); 0 uses the scalar unchanged.

Ports (clock and reset first):
- `clk` in 1: single clock. All logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset. This is the only reset in the block.
- `start` in 1: request. Sampled only in IDLE.
- `scalar` in WIDTH: scalar k. Sampled on the accepted `start`.
- `u_in` in WIDTH: base u-coordinate. Sampled on the accepted `start` and held internally for the step's `p_x`.
- `busy` out 1: high from the cycle after an accepted `start` through DONE.
- `done` out 1: one-cycle pulse in DONE.
- `x_out`, `z_out` out WIDTH: final R0. Valid from `done` until the next accepted `start`.
- `step_reset` out 1: active-high synchronous reset to the step instance.
- `step_enable` out 1: step enable.
- `step_x1`, `step_z1`, `step_x2`, `step_z2`, `step_px` out WIDTH: step operands. `step_x1`/`step_z1` = R0 (doubled), `step_x2`/`step_z2` = R1, `step_px` = u.
- `step_x_pd`, `step_z_pd`, `step_x_pa`, `step_z_pa` in WIDTH: step results.
- `step_done` in 1: step completion. Level-high until the next `step_reset`.

## Operation
States: IDLE, LOAD, SWAP, KICK, RUN, CAPTURE, FINAL, DONE.
- IDLE: `busy`=0, `step_reset`=1, `step_enable`=0.
  - `start`=1 latches `scalar` and `u_in` and moves to LOAD.
- LOAD: apply the clamp to the latched scalar if `CLAMP`.
  - Set R0=(1,0), R1=(u,1), swap=0, idx=`BITS-1`.
  - Go to SWAP.
- SWAP: compute b=k[idx] and e=swap^b.
  - If e=1, exchange R0 and R1 (both x and z) in registers.
  - swap<=b. Go to KICK.
- KICK: `step_reset`=1, `step_enable`=0 for exactly one cycle. This clears the step's sticky done. Go to RUN.
- RUN: `step_reset`=0, `step_enable`=1.
  - Operands are driven from the R0/R1/u registers and stay stable for the whole state.
  - Stay in RUN until `step_done`=1.
- CAPTURE: R0<=(`step_x_pd`,`step_z_pd`), R1<=(`step_x_pa`,`step_z_pa`). `step_enable`=0.
  - If idx==0, go to FINAL. Otherwise idx<=idx-1 and go to SWAP.
- FINAL: if swap=1, exchange R0 and R1. Copy R0 to `x_out`/`z_out`. Go to DONE.
- DONE: `done`=1 for one cycle. Return to IDLE.

Arithmetic and width rules:
- No arithmetic in this block. It only moves registers.
- Constants are zero-extended to WIDTH.
- idx is `$clog2(BITS)` bits wide and never wraps: idx==0 always exits to FINAL.

## Timing
- Reset (`reset`=0, any time, including mid-ladder):
  - State goes to IDLE. `busy`, `done`, `step_enable` go to 0. `step_reset` goes to 1.
  - `x_out`, `z_out`, R0, R1, swap, idx and the latched scalar/u all go to 0.
  - An in-flight step is abandoned. Its results are never captured.
- Let Ts = number of RUN cycles, counting the cycle in which `step_done` is first seen high.
- Per iteration: 3+Ts cycles (SWAP, KICK, RUN×Ts, CAPTURE).
- Latency: `done` rises exactly 2+BITS·(3+Ts)+1 cycles after the clock edge that samples `start`. These are LOAD, the iterations, FINAL, and DONE in the following cycle.
- `start` while `busy`=1 is ignored. `start` held high through DONE→IDLE starts a new run in the IDLE cycle.
- `step_done` outside RUN is ignored.
- `step_done` high in the first RUN cycle is legal (Ts=1).

## Test plan
- BITS=4, CLAMP=0, behavioural step stub with Ts=3 that returns x_pd=x1+1, z_pd=z1, x_pa=x2, z_pa=z2+1. Scalar=4'b1010, u=7.
  - Check the swap trace per iteration: e=1,1,1,1.
  - Check KICK pulse count = 4 and `done` at cycle 2+4·6+1 = 27.
  - Check x_out/z_out against a software model of the same stub.
- Same stub, scalar=0 with CLAMP=0: no swap ever occurs and x_out/z_out equal the model's R0 path.
- CLAMP=1, BITS=448, real `montgomery_step`, RFC 7748 §5.2 X448 vectors: x_out·z_out⁻¹ mod p matches the expected u-coordinate.
- Reset (`reset`=0) asserted during RUN of iteration 100, then released, then `start`:
  - Outputs are 0 after reset.
  - The second run's result is identical to a clean run.
- `start` pulsed every cycle during a run: exactly one `done`, latency unchanged.
- Stub holds `step_done`=1 continuously: every RUN is 1 cycle, and each KICK still drives `step_reset`=1 for exactly one cycle.
